scan_bist_ctrl: RTL and testbench
=================================

SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4, number of scan chains driven and compacted (1..16).
REQ-002 SHALL have parameter CHAIN_LEN, default 16, scan cells per chain (2..256).
REQ-003 SHALL have parameter NUM_PATTERNS, default 32, patterns applied per run (1..65535).
REQ-004 SHALL have parameter SEED, default 16'hACE1, PRPG start value (nonzero).
REQ-005 SHALL have port CK  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port RN  input  1  reset; one clock, asynchronous assert, active-low.
REQ-007 SHALL have port start  input  1  single-cycle run request.
REQ-008 SHALL have port so  input  NUM_CHAINS  scan-out of each chain's last cell.
REQ-009 SHALL have port se  output  1  scan enable to all SE pins of the SDFF cells.
REQ-010 SHALL have port si  output  NUM_CHAINS  scan-in to each chain's first cell.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  run complete; signature valid.
REQ-013 SHALL have port signature  output  16  MISR contents.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-015 SHALL move from IDLE or DONE to SHIFT on a clock edge with start=1, at that edge loading the PRPG with SEED and clearing the MISR, the pattern counter and the shift counter.
REQ-016 SHALL ignore start while in SHIFT, CAPTURE or UNLOAD.
REQ-017 SHALL stay in SHIFT for exactly CHAIN_LEN cycles, then enter CAPTURE.
REQ-018 SHALL stay in CAPTURE for exactly 1 cycle and increment the pattern counter.
REQ-019 SHALL go from CAPTURE to SHIFT while the pattern counter is below NUM_PATTERNS, and otherwise to UNLOAD.
REQ-020 SHALL stay in UNLOAD for exactly CHAIN_LEN cycles, then enter DONE.
REQ-021 SHALL stay in DONE until start is seen or reset asserts.
REQ-022 SHALL drive se=1 in SHIFT and UNLOAD and se=0 in IDLE, CAPTURE and DONE, with se from a flop (no combinational glitch).
REQ-023 SHALL drive si[i]=PRPG[i] in SHIFT and si=0 in all other states.
REQ-024 SHALL implement the PRPG as a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting toward the MSB with the feedback bit entering bit 0.
REQ-025 SHALL advance the PRPG once per SHIFT cycle and hold it in all other states.
REQ-026 SHALL implement the MISR as a 16-bit LFSR with the same polynomial, where each update is next = lfsr_step(MISR) XOR zero-extended so.
REQ-027 SHALL update the MISR on every SHIFT cycle with pattern counter >=1 and on every UNLOAD cycle, and hold it otherwise.
REQ-028 SHALL NOT update the MISR during the first load, whose scan-out contents are unknown.
REQ-029 SHALL drive signature continuously from the MISR register.
REQ-030 SHALL drive busy=1 in SHIFT, CAPTURE and UNLOAD, and busy=0 otherwise.
REQ-031 SHALL drive done=1 only in DONE.
REQ-032 SHALL size the shift counter at clog2(CHAIN_LEN)+1 bits and the pattern counter at 16 bits, neither of which may wrap within a run.
REQ-033 SHALL make the run length from the first SHIFT cycle to the first DONE cycle exactly NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles.

Reset
REQ-034 SHALL on RN=0, at any time including mid-run, immediately force: state IDLE, se=0, si=0, busy=0, done=0, signature=16'h0000, PRPG=SEED, both counters 0.
REQ-035 SHALL resume operation at the first rising CK after RN deasserts and require a fresh start.

Verification
REQ-036 SHALL verify reset: hold RN=0 with random start/so -> se=0, si=0, busy=0, done=0, signature=16'h0000.
REQ-037 SHALL verify the first shift, with defaults: pulse start -> busy=1 and se=1 next cycle, first si=4'b0001 (SEED[3:0]), se=1 for exactly 16 cycles, then se=0 for 1 cycle.
REQ-038 SHALL verify run length, with defaults: done rises exactly 560 cycles after the first SHIFT cycle, busy falls in the same cycle, and start held high during the run does not restart it.
REQ-039 SHALL verify zero response: so tied to 0 -> final signature=16'h0000.
REQ-040 SHALL verify against a model: behavioral SDFF chains (CHAIN_LEN cells each) built from si/se/so, with a fixed combinational function at capture -> signature matches a bit-accurate PRPG/MISR model; a single flipped so bit on any UNLOAD cycle -> signature mismatch.
REQ-041 SHALL verify reset mid-run: RN=0 during pattern 10, then release and pulse start -> outputs reset per REQ-034, and the run restarts from SEED with a signature identical to a clean run.

Source files
------------

// File: rtl/scan_bist_ctrl.sv
// ---------------------------------------------------------------------------
// scan_bist_ctrl
// Logic-BIST controller for a set of scan chains built from SDFF cells.
// A 16-bit PRPG feeds pseudo-random patterns into the chains. A 16-bit MISR
// compacts the chain responses into a signature.
// Each run is a sequence of shift / capture phases, one per pattern. A final
// unload phase then flushes the last captured response into the MISR.
//
// Ports
//   CK        : clock, all state changes on the rising edge
//   RN        : asynchronous active-low reset
//   start     : single-cycle run request (honoured in IDLE and DONE only)
//   so        : scan-out of the last cell of each chain
//   se        : scan enable to every SDFF SE pin (registered)
//   si        : scan-in to the first cell of each chain (registered)
//   busy      : run in progress
//   done      : run complete, signature valid
//   signature : MISR contents
// ---------------------------------------------------------------------------
module scan_bist_ctrl #(
    parameter int          NUM_CHAINS   = 4,
    parameter int          CHAIN_LEN    = 16,
    parameter int          NUM_PATTERNS = 32,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] so,
    output logic                  se,
    output logic [NUM_CHAINS-1:0] si,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           signature
);

    localparam int              SC_W      = $clog2(CHAIN_LEN) + 1;
    localparam logic [SC_W-1:0] SC_ZERO   = {SC_W{1'b0}};
    localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(CHAIN_LEN - 1);
    localparam logic [15:0]     PAT_TOTAL = 16'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t                  state_r,     state_s;
    logic [15:0]             prpg_r,      prpg_s;
    logic [15:0]             misr_r,      misr_s;
    logic [SC_W-1:0]         shift_cnt_r, shift_cnt_s;
    logic [15:0]             pat_cnt_r,   pat_cnt_s;
    logic [15:0]             so_ext_s;
    logic                    se_r,   se_s;
    logic [NUM_CHAINS-1:0]   si_r,   si_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;

    // Next-state, datapath updates and decode of the registered outputs.
    always_comb begin
        state_s     = state_r;
        prpg_s      = prpg_r;
        misr_s      = misr_r;
        shift_cnt_s = shift_cnt_r;
        pat_cnt_s   = pat_cnt_r;
        so_ext_s    = 16'h0000;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            so_ext_s[i] = so[i];
        end

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s     = SHIFT;
                    prpg_s      = SEED;
                    misr_s      = 16'h0000;
                    shift_cnt_s = SC_ZERO;
                    pat_cnt_s   = 16'h0000;
                end else begin
                    state_s = state_r;
                end
            end
            SHIFT: begin
                prpg_s = lfsr_step(prpg_r);
                // During the first load the chains hold unknown data.
                if (pat_cnt_r != 16'h0000) begin
                    misr_s = lfsr_step(misr_r) ^ so_ext_s;
                end else begin
                    misr_s = misr_r;
                end
                if (shift_cnt_r == SC_LAST) begin
                    shift_cnt_s = SC_ZERO;
                    state_s     = CAPTURE;
                end else begin
                    shift_cnt_s = shift_cnt_r + SC_ONE;
                end
            end
            CAPTURE: begin
                pat_cnt_s = pat_cnt_r + 16'h0001;
                if (pat_cnt_s < PAT_TOTAL) begin
                    state_s = SHIFT;
                end else begin
                    state_s = UNLOAD;
                end
            end
            UNLOAD: begin
                misr_s = lfsr_step(misr_r) ^ so_ext_s;
                if (shift_cnt_r == SC_LAST) begin
                    shift_cnt_s = SC_ZERO;
                    state_s     = DONE;
                end else begin
                    shift_cnt_s = shift_cnt_r + SC_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the flops present the
        // value belonging to the state being entered.
        se_s   = 1'b0;
        si_s   = {NUM_CHAINS{1'b0}};
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            SHIFT: begin
                se_s   = 1'b1;
                si_s   = prpg_s[NUM_CHAINS-1:0];
                busy_s = 1'b1;
            end
            CAPTURE: begin
                busy_s = 1'b1;
            end
            UNLOAD: begin
                se_s   = 1'b1;
                busy_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                se_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r     <= IDLE;
            prpg_r      <= SEED;
            misr_r      <= 16'h0000;
            shift_cnt_r <= SC_ZERO;
            pat_cnt_r   <= 16'h0000;
            se_r        <= 1'b0;
            si_r        <= {NUM_CHAINS{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            prpg_r      <= prpg_s;
            misr_r      <= misr_s;
            shift_cnt_r <= shift_cnt_s;
            pat_cnt_r   <= pat_cnt_s;
            se_r        <= se_s;
            si_r        <= si_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign se        = se_r;
    assign si        = si_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = misr_r;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_bist_ctrl
// Self-checking bench for scan_bist_ctrl with default parameters. Behavioural
// SDFF chains respond to se/si and return so. Expected signatures come from a
// pattern-level PRPG/MISR model that walks load, capture and unload directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_bist_ctrl;

    localparam int          N       = 4;
    localparam int          L       = 16;
    localparam int          NP      = 32;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          RUN_LEN = NP * (L + 1) + L;

    typedef logic [N-1:0][L-1:0] chains_t;

    typedef struct {
        logic         start;
        logic         exp_se;
        logic         exp_busy;
        logic         exp_done;
        logic [N-1:0] exp_si;
    } vec_t;

    logic          CK = 1'b0;
    logic          RN;
    logic          start;
    logic [N-1:0]  so;
    logic          se;
    logic [N-1:0]  si;
    logic          busy;
    logic          done;
    logic [15:0]   signature;

    int            n_checks = 0;
    int            n_fail   = 0;
    chains_t       env_ch;
    logic [15:0]   key;
    logic [1:0]    so_mode;
    logic [N-1:0]  so_rand;
    logic [N-1:0]  flip_mask;
    vec_t          tbl [20];

    scan_bist_ctrl #(
        .NUM_CHAINS  (N),
        .CHAIN_LEN   (L),
        .NUM_PATTERNS(NP),
        .SEED        (SEED)
    ) dut (
        .CK       (CK),
        .RN       (RN),
        .start    (start),
        .so       (so),
        .se       (se),
        .si       (si),
        .busy     (busy),
        .done     (done),
        .signature(signature)
    );

    always #5 CK = ~CK;

    // Polynomial x^16+x^14+x^13+x^11+1 as a tap mask on bits 15,13,12,10.
    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    function automatic logic [15:0] prpg_at(input int k);
        logic [15:0] p;
        p = SEED;
        for (int i = 0; i < k; i++) p = step(p);
        return p;
    endfunction

    // Fixed combinational logic seen by each cell while se=0.
    function automatic chains_t capture(input chains_t ch, input logic [15:0] k);
        chains_t n;
        for (int c = 0; c < N; c++)
            for (int j = 0; j < L; j++)
                n[c][j] = ch[c][j] ^ ch[(c + 1) % N][(j + 1) % L] ^ k[(c * L + j) % 16];
        return n;
    endfunction

    function automatic logic [15:0] last_bits(input chains_t ch);
        logic [15:0] v;
        v = 16'h0000;
        for (int c = 0; c < N; c++) v[c] = ch[c][L-1];
        return v;
    endfunction

    // Pattern-level reference: load each pattern, capture, and finally unload.
    function automatic logic [15:0] model_sig(input logic [15:0] k);
        chains_t     ch;
        logic [15:0] p;
        logic [15:0] m;
        ch = '0;
        p  = SEED;
        m  = 16'h0000;
        for (int pat = 0; pat < NP; pat++) begin
            for (int s = 0; s < L; s++) begin
                if (pat > 0) m = step(m) ^ last_bits(ch);
                for (int c = 0; c < N; c++) ch[c] = {ch[c][L-2:0], p[c]};
                p = step(p);
            end
            ch = capture(ch, k);
        end
        for (int s = 0; s < L; s++) begin
            m = step(m) ^ last_bits(ch);
            for (int c = 0; c < N; c++) ch[c] = {ch[c][L-2:0], 1'b0};
        end
        return m;
    endfunction

    // Behavioural SDFF chains: shift when se=1, capture otherwise.
    always @(posedge CK) begin
        if (se) begin
            for (int c = 0; c < N; c++) env_ch[c] <= {env_ch[c][L-2:0], si[c]};
        end else begin
            env_ch <= capture(env_ch, key);
        end
    end

    // Scan-out source: chains (with optional fault), tied low, or random.
    always_comb begin
        so = {N{1'b0}};
        for (int c = 0; c < N; c++) so[c] = env_ch[c][L-1];
        so = so ^ flip_mask;
        if (so_mode == 2'd1) so = {N{1'b0}};
        else if (so_mode == 2'd2) so = so_rand;
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_diff(input string nm, input logic [31:0] act, input logic [31:0] bad);
        n_checks++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got %0h, must differ from %0h", nm, act, bad);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_se"},   32'(se),        32'h0);
        check({tag, "_si"},   32'(si),        32'h0);
        check({tag, "_busy"}, 32'(busy),      32'h0);
        check({tag, "_done"}, 32'(done),      32'h0);
        check({tag, "_sig"},  32'(signature), 32'h0);
    endtask

    // One run from IDLE/DONE: returns signature, DONE cycle index and busy
    // around the DONE transition. flip_at < 0 means no fault injection.
    task automatic run_once(input bit hold, input int flip_at, input int flip_bit,
                            output logic [15:0] sig, output int dcyc,
                            output logic busy_pre, output logic busy_post);
        int   cyc;
        logic prev_busy;
        start = 1'b1;
        tick();
        start     = hold;
        cyc       = 0;
        dcyc      = -1;
        prev_busy = 1'b0;
        busy_pre  = 1'b0;
        busy_post = 1'b1;
        while (cyc < RUN_LEN + 100 && dcyc < 0) begin
            if (done) begin
                dcyc      = cyc;
                busy_pre  = prev_busy;
                busy_post = busy;
            end else begin
                prev_busy = busy;
                flip_mask = (cyc == flip_at) ? (N'(1) << flip_bit) : {N{1'b0}};
                tick();
                cyc++;
            end
        end
        flip_mask = {N{1'b0}};
        start     = 1'b0;
        sig       = signature;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pv;
        logic [15:0] sig;
        logic [15:0] clean_sig;
        int          dcyc;
        int          n;
        int          fa;
        int          fb;
        logic        bpre;
        logic        bpost;

        // Vector table for the opening cycles of a run (start noise included).
        for (int i = 0; i < 20; i++) begin
            tbl[i].start    = (i % 5 == 2);
            tbl[i].exp_done = 1'b0;
            tbl[i].exp_busy = 1'b1;
            if (i < 16) begin
                pv = prpg_at(i);
                tbl[i].exp_se = 1'b1;
                tbl[i].exp_si = pv[N-1:0];
            end else if (i == 16) begin
                tbl[i].exp_se = 1'b0;
                tbl[i].exp_si = {N{1'b0}};
            end else begin
                pv = prpg_at(i - 1);
                tbl[i].exp_se = 1'b1;
                tbl[i].exp_si = pv[N-1:0];
            end
        end

        RN        = 1'b1;
        start     = 1'b0;
        so_mode   = 2'd0;
        so_rand   = {N{1'b0}};
        flip_mask = {N{1'b0}};
        key       = 16'h5A3C;
        #1 RN = 1'b0;

        // Reset held with random start / so.
        so_mode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            start   = 1'($urandom_range(0, 1));
            so_rand = N'($urandom);
            tick();
            check_reset_outputs("rst");
        end
        start   = 1'b0;
        so_mode = 2'd0;
        RN      = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_se",   32'(se),   32'h0);

        // Table-driven opening of a run.
        key   = 16'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("tbl%0d_se", i),   32'(se),   32'(tbl[i].exp_se));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
            check($sformatf("tbl%0d_si", i),   32'(si),   32'(tbl[i].exp_si));
            start = tbl[i].start;
            tick();
        end
        start = 1'b0;
        n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        check("tbl_run_len", 32'(20 + n), 32'(RUN_LEN));
        check("tbl_sig", 32'(signature), 32'(model_sig(key)));

        // Run length with start held high throughout.
        key = 16'($urandom);
        run_once(1'b1, -1, 0, sig, dcyc, bpre, bpost);
        check("len_done_cycle", 32'(dcyc),  32'(RUN_LEN));
        check("len_busy_before", 32'(bpre), 32'h1);
        check("len_busy_at_done", 32'(bpost), 32'h0);
        check("len_sig", 32'(sig), 32'(model_sig(key)));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_hold", 32'(done), 32'h1);
            check("done_idle_busy", 32'(busy), 32'h0);
        end

        // Zero response.
        so_mode = 2'd1;
        run_once(1'b0, -1, 0, sig, dcyc, bpre, bpost);
        check("zero_done_cycle", 32'(dcyc), 32'(RUN_LEN));
        check("zero_sig", 32'(sig), 32'h0);
        so_mode = 2'd0;

        // Random capture functions against the model.
        for (int r = 0; r < 3; r++) begin
            key = 16'($urandom);
            run_once(1'b0, -1, 0, sig, dcyc, bpre, bpost);
            check($sformatf("rand%0d_sig", r), 32'(sig), 32'(model_sig(key)));
        end

        // Single flipped so bit during UNLOAD must corrupt the signature.
        for (int r = 0; r < 2; r++) begin
            key = 16'($urandom);
            fa  = $urandom_range(RUN_LEN - 1, RUN_LEN - L);
            fb  = $urandom_range(N - 1, 0);
            run_once(1'b0, fa, fb, sig, dcyc, bpre, bpost);
            check_diff($sformatf("flip%0d_sig", r), 32'(sig), 32'(model_sig(key)));
        end

        // Reset during pattern 10, then a fresh run with the same key.
        key = 16'($urandom);
        run_once(1'b0, -1, 0, clean_sig, dcyc, bpre, bpost);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 * (L + 1) + 5; i++) tick();
        check("mid_busy_before_rst", 32'(busy), 32'h1);
        #2 RN = 1'b0;
        #1;
        check_reset_outputs("mid_rst_async");
        tick();
        check_reset_outputs("mid_rst_held");
        RN = 1'b0;
        tick();
        RN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_autostart_busy", 32'(busy), 32'h0);
            check("mid_no_autostart_done", 32'(done), 32'h0);
        end
        run_once(1'b0, -1, 0, sig, dcyc, bpre, bpost);
        check("mid_done_cycle", 32'(dcyc), 32'(RUN_LEN));
        check("mid_sig_vs_clean", 32'(sig), 32'(clean_sig));
        check("mid_sig_vs_model", 32'(sig), 32'(model_sig(key)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
